cnt_share_arb: RTL and testbench

//  Round-robin arbiter/sequencer that time-shares one up-counter among N_REQ

---
 rtl/cnt_share_arb.sv | 147 ++++++++++++++
 tb/tb_cnt_share_arb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_share_arb.sv
// cnt_share_arb
//   Round-robin sequencer that time-shares a single up-counter among N_REQ
//   requesters. The winning requester owns the counter for max(len,1) cycles
//   of counting plus one DONE cycle, after which the counter is handed on.
//
// Ports
//   clk      in   single clock, posedge
//   reset    in   synchronous active-high reset
//   req      in   level request per client, held until done/abort
//   req_len  in   per-client interval length, slice k = req_len[k*CNT_W +: CNT_W]
//   grant    out  one-hot owner (registered), 0 when idle
//   owner    out  index of current/last owner (registered)
//   busy     out  high while an interval is running or in its DONE cycle
//   cnt      out  shared counter value (registered)
//   done     out  one-hot 1-cycle pulse when the owner's interval completes
//   aborted  out  1-cycle pulse when the owner dropped req before completion
module cnt_share_arb #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 32,
  parameter int IDX_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] req_len,
  output logic [N_REQ-1:0]       grant,
  output logic [IDX_W-1:0]       owner,
  output logic                   busy,
  output logic [CNT_W-1:0]       cnt,
  output logic [N_REQ-1:0]       done,
  output logic                   aborted
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_len;
  logic [N_REQ-1:0]   r_grant;
  logic [IDX_W-1:0]   r_owner;
  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_REQ-1:0]   r_done;
  logic               r_aborted;

  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic [CNT_W-1:0]   w_pick_len;
  int unsigned        w_idx;
  logic [IDX_W-1:0]   w_next_ptr;
  logic               w_owner_req;
  logic               w_last;

  // Circular search starting at r_ptr; the first set request wins.
  always_comb begin
    w_found    = 1'b0;
    w_pick     = '0;
    w_idx      = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_idx = 32'(r_ptr) + i;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && req[IDX_W'(w_idx)]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(w_idx);
      end
    end
    w_pick_len = req_len[32'(w_pick)*CNT_W +: CNT_W];
    if (w_pick_len == '0) w_pick_len = CNT_W'(1);
  end

  assign w_next_ptr  = (r_owner == IDX_W'(N_REQ-1)) ? '0 : r_owner + 1'b1;
  assign w_owner_req = req[r_owner];
  assign w_last      = (r_cnt == r_len - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_len     <= '0;
      r_grant   <= '0;
      r_owner   <= '0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_done    <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_done    <= '0;
      r_aborted <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt   <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          if (w_found) begin
            r_state <= ST_RUN;
            r_grant <= N_REQ'(1) << w_pick;
            r_owner <= w_pick;
            r_len   <= w_pick_len;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          // Dropping req wins over completion on the same edge.
          if (!w_owner_req) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
            r_ptr     <= w_next_ptr;
          end else if (w_last) begin
            r_state <= ST_DONE;
            r_cnt   <= r_len;
            r_done  <= r_grant;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= w_next_ptr;
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant   = r_grant;
  assign owner   = r_owner;
  assign busy    = r_busy;
  assign cnt     = r_cnt;
  assign done    = r_done;
  assign aborted = r_aborted;

endmodule

// File: tb/tb_cnt_share_arb.sv
// tb_cnt_share_arb
//   Drives cnt_share_arb (N_REQ=4, CNT_W=8) with directed scenarios followed by
//   random request/length/reset traffic, and compares every output each cycle
//   against a time-based reference model of the interval schedule.
module tb_cnt_share_arb;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_len;
  logic [N-1:0]   grant;
  logic [IW-1:0]  owner;
  logic           busy;
  logic [W-1:0]   cnt;
  logic [N-1:0]   done;
  logic           aborted;

  always #5 clk = ~clk;

  cnt_share_arb #(
    .N_REQ(N),
    .CNT_W(W),
    .IDX_W(IW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .req_len(req_len),
    .grant  (grant),
    .owner  (owner),
    .busy   (busy),
    .cnt    (cnt),
    .done   (done),
    .aborted(aborted)
  );

  // Reference model: an interval is described by its owner, its clamped
  // length and the number of edges elapsed since the grant (t). t runs
  // 0..len-1 while counting and equals len in the completion cycle.
  bit m_active;
  int m_owner;
  int m_len;
  int m_t;
  int m_ptr;
  bit m_aborted;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int len_of(input int k);
    logic [W-1:0] v;
    v = req_len[k*W +: W];
    return int'(v);
  endfunction

  task automatic model_step();
    int k;
    bit found;
    if (reset) begin
      m_active  = 0;
      m_owner   = 0;
      m_len     = 0;
      m_t       = 0;
      m_ptr     = 0;
      m_aborted = 0;
      return;
    end
    m_aborted = 0;
    if (!m_active) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (!found && req[k]) begin
          found    = 1;
          m_active = 1;
          m_owner  = k;
          m_len    = (len_of(k) == 0) ? 1 : len_of(k);
          m_t      = 0;
        end
      end
    end else if (m_t < m_len) begin
      if (!req[m_owner]) begin
        m_active  = 0;
        m_aborted = 1;
        m_ptr     = (m_owner + 1) % N;
      end else begin
        m_t++;
      end
    end else begin
      m_active = 0;
      m_ptr    = (m_owner + 1) % N;
    end
  endtask

  task automatic compare();
    logic [31:0] e_grant;
    logic [31:0] e_done;
    e_grant = m_active ? (32'd1 << m_owner) : 32'd0;
    e_done  = (m_active && m_t == m_len) ? (32'd1 << m_owner) : 32'd0;
    chk("grant",   32'(grant),   e_grant);
    chk("owner",   32'(owner),   32'(m_owner));
    chk("busy",    32'(busy),    32'(m_active));
    chk("cnt",     32'(cnt),     m_active ? 32'(m_t) : 32'd0);
    chk("done",    32'(done),    e_done);
    chk("aborted", 32'(aborted), 32'(m_aborted));
    chk("onehot",  32'($onehot0(grant)), 32'd1);
    chk("excl",    32'((done != '0) && aborted), 32'd0);
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
    end
  endtask

  task automatic set_len(input int k, input int v);
    req_len[k*W +: W] = W'(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    req_len = '0;
    tick(2);
    reset = 1'b0;

    // Single request, len 3.
    set_len(0, 3);
    req = 4'b0001;
    tick(5);
    req = '0;
    tick(2);

    // Round robin with all lengths 2.
    do_reset();
    for (int k = 0; k < N; k++) set_len(k, 2);
    req = 4'b1111;
    tick(20);
    req = '0;
    tick(3);

    // Abort at cnt 4, then requester 3 must win.
    do_reset();
    set_len(2, 10);
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (cnt == W'(4)) break;
    end
    req = 4'b1001;
    tick(8);
    req = '0;
    tick(3);

    // Zero length clamps to 1.
    do_reset();
    set_len(1, 0);
    req = 4'b0010;
    tick(3);
    req = '0;
    tick(3);

    // Reset in the middle of a long interval.
    do_reset();
    set_len(0, 100);
    req = 4'b0001;
    tick(51);
    reset = 1'b1;
    req   = 4'b1001;
    tick(1);
    reset = 1'b0;
    tick(4);
    req = '0;
    tick(3);

    // Maximum length: counter reaches 255 without wrapping.
    do_reset();
    set_len(0, 255);
    req = 4'b0001;
    tick(257);
    req = '0;
    tick(3);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < N; k++) begin
        if (req[k]) begin
          if ($urandom_range(0, 29) == 0) req[k] = 1'b0;
        end else begin
          if ($urandom_range(0, 3) == 0) req[k] = 1'b1;
        end
        if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 49) == 0) set_len(k, int'($urandom_range(0, 40)));
          else                            set_len(k, int'($urandom_range(0, 5)));
        end
      end
      tick(1);
    end
    reset = 1'b0;
    req   = '0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
